// File: rtl/sum_accumulator.sv
// Accumulates BATCH 9-bit adder results into a 16-bit total, then streams the
// total out as two bytes (low first) over a valid/ready handshake.
module sum_accumulator #(
  parameter int BATCH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sum,
  input  logic       in_cout,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(BATCH - 1);

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        overflow_q, overflow_d;

  logic        accept;
  logic        transfer;
  logic [16:0] sum_ext;

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= 16'd0;
      cnt_q      <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Bit 16 of the widened sum is the carry out of the 16-bit accumulator.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    sum_ext    = {1'b0, acc_q} + {8'd0, in_cout, in_sum};
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d      = sum_ext[15:0];
          cnt_d      = cnt_q + 8'd1;
          overflow_d = overflow_q | sum_ext[16];
        end
        // A flush alongside an accept closes the batch with that beat included.
        if ((accept && (cnt_q == LAST_CNT)) ||
            (flush && (accept || (cnt_q != 8'd0)))) begin
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (transfer) state_d = SEND_HI;
      end
      SEND_HI: begin
        if (transfer) begin
          state_d    = ACCUM;
          acc_d      = 16'd0;
          cnt_d      = 8'd0;
          overflow_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_ready = ~rst;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_byte  = acc_q[7:0];
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_byte  = acc_q[15:8];
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: a reference model pushes expected bytes into a
// scoreboard queue as batches close; they are compared as the DUTs emit them.
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       iv0 = 1'b0, cout0 = 1'b0, fl0 = 1'b0, ordy0 = 1'b0;
  logic [7:0] sum0 = 8'h00;
  logic       rdy0, ov0, ol0, of0;
  logic [7:0] ob0;

  logic       iv1 = 1'b0, cout1 = 1'b0, fl1 = 1'b0, ordy1 = 1'b0;
  logic [7:0] sum1 = 8'h00;
  logic       rdy1, ov1, ol1, of1;
  logic [7:0] ob1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  int          m_state [2];
  logic [15:0] m_acc   [2];
  int          m_cnt   [2];
  logic        m_ovf   [2];

  always #5 clk = ~clk;

  sum_accumulator #(.BATCH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .in_sum(sum0),
    .in_cout(cout0), .flush(fl0), .out_valid(ov0), .out_ready(ordy0),
    .out_byte(ob0), .out_last(ol0), .overflow(of0)
  );

  sum_accumulator #(.BATCH(255)) dut_ovf (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_sum(sum1),
    .in_cout(cout1), .flush(fl1), .out_valid(ov1), .out_ready(ordy1),
    .out_byte(ob1), .out_last(ol1), .overflow(of1)
  );

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: checks the current cycle, then advances to the next.
  task automatic modelStep(input int id, input int batch, input logic r, input logic iv,
                           input logic [8:0] val, input logic fl, input logic ordy,
                           input logic dv, input logic drdy, input logic [7:0] db,
                           input logic dl, input logic dovf);
    logic [16:0] s;
    exp_t e;
    exp_t nq[$];
    checkOutput($sformatf("dut%0d.in_ready", id), 16'(drdy), 16'((m_state[id] == 0) && !r));
    checkOutput($sformatf("dut%0d.out_valid", id), 16'(dv), 16'(m_state[id] != 0));
    checkOutput($sformatf("dut%0d.overflow", id), 16'(dovf), 16'(m_ovf[id]));
    if (m_state[id] != 0) begin
      if (exp_q.size() == 0) begin
        checkOutput($sformatf("dut%0d.scoreboard_empty", id), 16'd1, 16'd0);
      end else begin
        e = exp_q[0];
        checkOutput($sformatf("dut%0d.sb_owner", id), 16'(e.id), 16'(id));
        checkOutput($sformatf("dut%0d.out_byte", id), 16'(db), 16'(e.b));
        checkOutput($sformatf("dut%0d.out_last", id), 16'(dl), 16'(e.last));
      end
    end
    if (r) begin
      m_state[id] = 0;
      m_acc[id]   = 16'd0;
      m_cnt[id]   = 0;
      m_ovf[id]   = 1'b0;
      foreach (exp_q[k]) if (exp_q[k].id != id) nq.push_back(exp_q[k]);
      exp_q = nq;
    end else begin
      case (m_state[id])
        0: begin
          if (iv) begin
            s = {1'b0, m_acc[id]} + 17'(val);
            if (s[16]) m_ovf[id] = 1'b1;
            m_acc[id] = s[15:0];
            m_cnt[id]++;
          end
          if ((iv && m_cnt[id] == batch) || (fl && m_cnt[id] > 0)) begin
            exp_q.push_back('{id: id, b: m_acc[id][7:0], last: 1'b0});
            exp_q.push_back('{id: id, b: m_acc[id][15:8], last: 1'b1});
            m_state[id] = 1;
          end
        end
        1: if (ordy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_state[id] = 2;
        end
        default: if (ordy) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_state[id] = 0;
          m_acc[id]   = 16'd0;
          m_cnt[id]   = 0;
          m_ovf[id]   = 1'b0;
        end
      endcase
    end
  endtask

  always @(negedge clk) begin
    modelStep(0, 4, rst, iv0, {cout0, sum0}, fl0, ordy0, ov0, rdy0, ob0, ol0, of0);
    modelStep(1, 255, rst, iv1, {cout1, sum1}, fl1, ordy1, ov1, rdy1, ob1, ol1, of1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic v, input logic [8:0] val,
                               input logic fl, input logic ordy);
    if (id == 0) begin
      iv0 = v; {cout0, sum0} = val; fl0 = fl; ordy0 = ordy;
    end else begin
      iv1 = v; {cout1, sum1} = val; fl1 = fl; ordy1 = ordy;
    end
    tick();
  endtask

  task automatic readOut(input int id, output logic v, output logic [7:0] b,
                         output logic l, output logic o, output logic r);
    if (id == 0) begin
      v = ov0; b = ob0; l = ol0; o = of0; r = rdy0;
    end else begin
      v = ov1; b = ob1; l = ol1; o = of1; r = rdy1;
    end
  endtask

  // Expects the DUT to have just entered SEND_LO with out_ready held high.
  task automatic checkBatch(input string tag, input int id, input logic [7:0] lo,
                            input logic [7:0] hi, input logic ovf);
    logic v, l, o, r;
    logic [7:0] b;
    readOut(id, v, b, l, o, r);
    checkOutput({tag, ".lo_valid"}, 16'(v), 16'd1);
    checkOutput({tag, ".lo_byte"}, 16'(b), 16'(lo));
    checkOutput({tag, ".lo_last"}, 16'(l), 16'd0);
    checkOutput({tag, ".lo_ovf"}, 16'(o), 16'(ovf));
    checkOutput({tag, ".lo_ready"}, 16'(r), 16'd0);
    applyStimulus(id, 1'b0, 9'd0, 1'b0, 1'b1);
    readOut(id, v, b, l, o, r);
    checkOutput({tag, ".hi_valid"}, 16'(v), 16'd1);
    checkOutput({tag, ".hi_byte"}, 16'(b), 16'(hi));
    checkOutput({tag, ".hi_last"}, 16'(l), 16'd1);
    checkOutput({tag, ".hi_ovf"}, 16'(o), 16'(ovf));
    applyStimulus(id, 1'b0, 9'd0, 1'b0, 1'b1);
    readOut(id, v, b, l, o, r);
    checkOutput({tag, ".done_valid"}, 16'(v), 16'd0);
    checkOutput({tag, ".done_ready"}, 16'(r), 16'd1);
    checkOutput({tag, ".done_ovf"}, 16'(o), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_acc[i] = 16'd0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset.out_valid", 16'(ov0), 16'd0);
    checkOutput("reset.out_byte", 16'(ob0), 16'h00);
    checkOutput("reset.out_last", 16'(ol0), 16'd0);
    checkOutput("reset.overflow", 16'(of0), 16'd0);
    checkOutput("reset.in_ready", 16'(rdy0), 16'd1);

    $display("[TB] basic batch");
    applyStimulus(0, 1'b1, 9'h010, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 9'h020, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 9'h100, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 9'h005, 1'b0, 1'b1);
    checkBatch("basic", 0, 8'h35, 8'h01, 1'b0);

    $display("[TB] flush");
    applyStimulus(0, 1'b1, 9'h080, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 9'h080, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 9'h1AA, 1'b1, 1'b1);
    checkBatch("flush2", 0, 8'h00, 8'h01, 1'b0);
    applyStimulus(0, 1'b0, 9'h1FF, 1'b1, 1'b1);
    checkOutput("flush_empty.in_ready", 16'(rdy0), 16'd1);
    checkOutput("flush_empty.out_valid", 16'(ov0), 16'd0);
    applyStimulus(0, 1'b1, 9'h080, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 9'h080, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 9'h001, 1'b1, 1'b1);
    checkBatch("flush3", 0, 8'h01, 8'h01, 1'b0);

    $display("[TB] backpressure");
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < 60 && !ov0; k++)
        applyStimulus(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'b0, 1'b0);
      if (!ov0) checkOutput("bp.timeout", 16'd0, 16'd1);
      for (int k = 0; k < 5; k++)
        applyStimulus(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 9'd0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++)
        applyStimulus(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 9'd0, 1'b0, 1'b1);
    end

    $display("[TB] overflow");
    for (int k = 0; k < 255; k++) applyStimulus(1, 1'b1, 9'h1FF, 1'b0, 1'b1);
    checkBatch("overflow", 1, 8'h01, 8'hFD, 1'b1);

    $display("[TB] reset during SEND_HI");
    for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 9'h0C3, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 9'd0, 1'b0, 1'b1);
    checkOutput("rst_mid.in_hi", 16'(ol0), 16'd1);
    ordy0 = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("rst_mid.out_valid", 16'(ov0), 16'd0);
    checkOutput("rst_mid.out_byte", 16'(ob0), 16'h00);
    checkOutput("rst_mid.overflow", 16'(of0), 16'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(0, 1'b1, 9'h011, 1'b0, 1'b1);
    checkBatch("after_rst", 0, 8'h44, 8'h00, 1'b0);

    applyStimulus(0, 1'b0, 9'd0, 1'b0, 1'b0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
